// File: rtl/sprite_blitter_pkg.sv
// Shared types and constants for the sprite blitter.
// Screen geometry, colour codes and FSM encoding.
package blitter_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int FB_DEPTH = SCREEN_W * SCREEN_H;
  localparam int FB_AW    = 19;
  localparam int ROM_AW   = 12;

  localparam logic [4:0] TRANSPARENT_CODE = 5'h15;

  typedef logic signed [11:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_BLIT,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [10:0]       x;
    logic [10:0]       y;
    logic [6:0]        w;
    logic [6:0]        h;
    logic [ROM_AW-1:0] base;
    logic [4:0]        color;
  } cmd_t;

  // Only meaningful for on-screen points; callers gate with in_range.
  function automatic logic [FB_AW-1:0] fb_index(
    input coord_t sx,
    input coord_t sy
  );
    return FB_AW'(sy) * FB_AW'(SCREEN_W) + FB_AW'(sx);
  endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Command, sprite ROM and frame buffer signals of the blitter.
// master = control/ROM side, slave = blitter.
interface sprite_blitter_if;
  import blitter_pkg::*;

  logic              start;
  logic              clear;
  logic [10:0]       spr_x;
  logic [10:0]       spr_y;
  logic [6:0]        spr_w;
  logic [6:0]        spr_h;
  logic [ROM_AW-1:0] rom_base;
  logic [4:0]        fill_color;
  logic [ROM_AW-1:0] rom_addr;
  logic [4:0]        rom_data;
  logic              fb_we;
  logic [FB_AW-1:0]  fb_addr;
  logic [4:0]        fb_data;
  logic              busy;
  logic              done;

  modport master (
    output start, clear, spr_x, spr_y,
    output spr_w, spr_h, rom_base,
    output fill_color, rom_data,
    input  rom_addr, fb_we, fb_addr,
    input  fb_data, busy, done
  );

  modport slave (
    input  start, clear, spr_x, spr_y,
    input  spr_w, spr_h, rom_base,
    input  fill_color, rom_data,
    output rom_addr, fb_we, fb_addr,
    output fb_data, busy, done
  );

endinterface

// File: rtl/sprite_blitter_addr_gen.sv
// Row-major pixel scan: ROM address, screen coordinate
// and clip flag for the pixel issued this cycle.
module blit_addr_gen
  import blitter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [10:0]       x_i,
  input  logic [10:0]       y_i,
  input  logic [6:0]        w_i,
  input  logic [6:0]        h_i,
  input  logic [ROM_AW-1:0] base_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  output coord_t            sx_o,
  output coord_t            sy_o,
  output logic              in_range_o,
  output logic              last_o
);

  logic [5:0]        col_q;
  logic [5:0]        row_q;
  logic [ROM_AW-1:0] off_q;
  logic              col_end;
  logic              row_end;

  assign col_end = {1'b0, col_q} == w_i - 7'd1;
  assign row_end = {1'b0, row_q} == h_i - 7'd1;
  assign last_o  = col_end & row_end;

  // off_q tracks row*w+col without a multiplier.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
      off_q <= '0;
    end else if (load_i) begin
      col_q <= '0;
      row_q <= '0;
      off_q <= '0;
    end else if (step_i) begin
      off_q <= off_q + ROM_AW'(1);
      if (col_end) begin
        col_q <= '0;
        row_q <= row_q + 6'd1;
      end else begin
        col_q <= col_q + 6'd1;
      end
    end
  end

  assign rom_addr_o = base_i + off_q;
  assign sx_o = $signed({x_i[10], x_i})
              + $signed({6'd0, col_q});
  assign sy_o = $signed({y_i[10], y_i})
              + $signed({6'd0, row_q});

  assign in_range_o = !sx_o[11]
                    && (sx_o < 12'sd640)
                    && !sy_o[11]
                    && (sy_o < 12'sd480);

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blit / screen clear engine feeding the
// frame buffer write port, one pixel per clock.
module sprite_blitter
  import blitter_pkg::*;
(
  input logic             clk_i,
  input logic             rst_i,
  sprite_blitter_if.slave bus
);

  state_e           state_q;
  cmd_t             cmd_q;
  logic [FB_AW-1:0] clr_cnt_q;
  logic [FB_AW-1:0] s2_addr_q;
  logic             s2_vld_q;
  logic             s2_in_q;

  logic [ROM_AW-1:0] gen_addr;
  coord_t            sx;
  coord_t            sy;
  logic              in_range;
  logic              last;
  logic              load;
  logic              step;
  logic              zero_sz;
  logic              wr_blit;
  logic              fb_we;
  logic [FB_AW-1:0]  fb_addr;
  logic [4:0]        fb_data;

  assign load    = (state_q == S_IDLE) & bus.start;
  assign step    = state_q == S_BLIT;
  assign zero_sz = (bus.spr_w == 7'd0)
                 | (bus.spr_h == 7'd0);

  blit_addr_gen u_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .step_i     (step),
    .x_i        (cmd_q.x),
    .y_i        (cmd_q.y),
    .w_i        (cmd_q.w),
    .h_i        (cmd_q.h),
    .base_i     (cmd_q.base),
    .rom_addr_o (gen_addr),
    .sx_o       (sx),
    .sy_o       (sy),
    .in_range_o (in_range),
    .last_o     (last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      clr_cnt_q <= '0;
      s2_addr_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_in_q   <= 1'b0;
    end else begin
      // Stage 2 lines up with rom_data one cycle later.
      s2_vld_q  <= step;
      s2_in_q   <= in_range;
      s2_addr_q <= fb_index(sx, sy);
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            cmd_q <= '{x:     bus.spr_x,
                       y:     bus.spr_y,
                       w:     bus.spr_w,
                       h:     bus.spr_h,
                       base:  bus.rom_base,
                       color: bus.fill_color};
            clr_cnt_q <= '0;
            if (bus.clear)
              state_q <= S_CLEAR;
            else if (zero_sz)
              state_q <= S_DONE;
            else
              state_q <= S_BLIT;
          end
        end
        S_CLEAR: begin
          if (clr_cnt_q == FB_AW'(FB_DEPTH - 1))
            state_q <= S_DONE;
          else
            clr_cnt_q <= clr_cnt_q + FB_AW'(1);
        end
        S_BLIT: begin
          if (last)
            state_q <= S_DRAIN;
        end
        S_DRAIN: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_blit = s2_vld_q & s2_in_q
                 & (bus.rom_data != TRANSPARENT_CODE);

  always_comb begin
    fb_we   = 1'b0;
    fb_addr = '0;
    fb_data = '0;
    unique case (1'b1)
      (state_q == S_CLEAR): begin
        fb_we   = 1'b1;
        fb_addr = clr_cnt_q;
        fb_data = cmd_q.color;
      end
      wr_blit: begin
        fb_we   = 1'b1;
        fb_addr = s2_addr_q;
        fb_data = bus.rom_data;
      end
      default: ;
    endcase
  end

  assign bus.fb_we    = fb_we;
  assign bus.fb_addr  = fb_addr;
  assign bus.fb_data  = fb_data;
  assign bus.rom_addr = step ? gen_addr : '0;
  assign bus.busy     = (state_q == S_CLEAR)
                      | (state_q == S_BLIT)
                      | (state_q == S_DRAIN);
  assign bus.done     = state_q == S_DONE;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: directed table, corner
// sequences and random blits against a pixel model.
module tb_sprite_blitter;
  import blitter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_blitter_if bif ();

  sprite_blitter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  logic [4:0] rom [0:4095];
  always @(posedge clk) bif.rom_data <= rom[bif.rom_addr];

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Expected write for pixel k, straight from the scan/clip rules.
  task automatic exp_px(input int x, input int y, input int w,
                        input int base, input int k,
                        output bit we, output int addr,
                        output int data);
    int sx, sy, d;
    sx = x + k % w;
    sy = y + k / w;
    d  = int'(rom[(base + k) % 4096]);
    we = sx >= 0 && sx < 640 && sy >= 0 && sy < 480 && d != 21;
    addr = we ? sy * 640 + sx : 0;
    data = we ? d : 0;
  endtask

  task automatic run_blit(input int x, input int y, input int w,
                          input int h, input int base, input bit poke,
                          output int nwr, output int dcyc,
                          output int faddr, output int fcyc);
    int  n;
    bit  seen;
    bit  ewe;
    int  ea, ed;
    n = w * h;
    seen = 0;
    nwr = 0; dcyc = -1; faddr = -1; fcyc = -1;
    @(negedge clk);
    bif.start = 1'b1;
    bif.clear = 1'b0;
    bif.spr_x = 11'(x);
    bif.spr_y = 11'(y);
    bif.spr_w = 7'(w);
    bif.spr_h = 7'(h);
    bif.rom_base = 12'(base);
    bif.fill_color = 5'($urandom);
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    bif.clear = 1'($urandom);
    bif.spr_x = 11'($urandom);
    bif.spr_y = 11'($urandom);
    bif.spr_w = 7'($urandom_range(0, 64));
    bif.spr_h = 7'($urandom_range(0, 64));
    bif.rom_base = 12'($urandom);
    for (int c = 1; c <= n + 10 && !seen; c++) begin
      @(negedge clk);
      if (c >= 2 && c - 2 < n)
        exp_px(x, y, w, base, c - 2, ewe, ea, ed);
      else begin
        ewe = 0; ea = 0; ed = 0;
      end
      chk("rom_addr", int'(bif.rom_addr),
          (c <= n) ? (base + c - 1) % 4096 : 0);
      chk("fb_we", int'(bif.fb_we), int'(ewe));
      chk("fb_addr", int'(bif.fb_addr), ea);
      chk("fb_data", int'(bif.fb_data), ed);
      chk("busy", int'(bif.busy), int'(n > 0 && c <= n + 1));
      chk("done", int'(bif.done),
          int'((n > 0) ? (c == n + 2) : (c == 1)));
      if (bif.fb_we) begin
        nwr++;
        if (fcyc < 0) begin
          fcyc = c;
          faddr = int'(bif.fb_addr);
        end
      end
      if (bif.done) begin
        seen = 1;
        dcyc = c;
      end
      if (poke && c == 2) begin
        bif.start = 1'b1;
        bif.clear = 1'b1;
      end else if (poke && c == 3) begin
        bif.start = 1'b0;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("after_done", int'(bif.done), 0);
    chk("after_busy", int'(bif.busy), 0);
  endtask

  typedef struct {
    int x, y, w, h, base;
    int nwr, done, faddr, fcyc;
  } vec_t;

  vec_t vecs [8];

  task automatic check_vec(input vec_t v, input bit poke);
    int nwr, dc, fa, fc;
    run_blit(v.x, v.y, v.w, v.h, v.base, poke, nwr, dc, fa, fc);
    chk("vec_nwr", nwr, v.nwr);
    chk("vec_done", dc, v.done);
    chk("vec_faddr", fa, v.faddr);
    chk("vec_fcyc", fc, v.fcyc);
  endtask

  initial begin
    int nwr, dc, fa, fc;
    for (int i = 0; i < 4096; i++) rom[i] = 5'($urandom);
    rom[100] = 5'd3; rom[101] = 5'h15;
    rom[102] = 5'd7; rom[103] = 5'd9;
    for (int i = 200; i < 204; i++) rom[i] = 5'd1;
    for (int i = 300; i < 304; i++) rom[i] = 5'd1;
    for (int i = 400; i < 412; i++) rom[i] = 5'd2;
    for (int i = 500; i < 516; i++) rom[i] = 5'd6;
    for (int i = 4092; i < 4096; i++) rom[i] = 5'd3;
    for (int i = 0; i < 4; i++) rom[i] = 5'd3;

    vecs[0] = '{10, 5, 2, 2, 100, 3, 6, 3210, 2};
    vecs[1] = '{-1, 479, 2, 2, 200, 1, 6, 306560, 3};
    vecs[2] = '{30, 30, 0, 5, 100, 0, 1, -1, -1};
    vecs[3] = '{30, 30, 3, 0, 100, 0, 1, -1, -1};
    vecs[4] = '{700, 0, 3, 2, 100, 0, 8, -1, -1};
    vecs[5] = '{638, 0, 4, 1, 300, 2, 6, 638, 2};
    vecs[6] = '{-3, -2, 4, 3, 400, 1, 14, 0, 13};
    vecs[7] = '{0, 10, 8, 1, 4092, 8, 10, 6400, 2};

    bif.start = 1'b0; bif.clear = 1'b0;
    bif.spr_x = '0; bif.spr_y = '0;
    bif.spr_w = '0; bif.spr_h = '0;
    bif.rom_base = '0; bif.fill_color = '0;

    repeat (3) @(negedge clk);
    chk("rst_fb_we", int'(bif.fb_we), 0);
    chk("rst_busy", int'(bif.busy), 0);
    chk("rst_done", int'(bif.done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_fb_we", int'(bif.fb_we), 0);
    chk("idle_rom_addr", int'(bif.rom_addr), 0);
    chk("idle_fb_addr", int'(bif.fb_addr), 0);
    chk("idle_fb_data", int'(bif.fb_data), 0);
    chk("idle_busy", int'(bif.busy), 0);
    chk("idle_done", int'(bif.done), 0);

    foreach (vecs[i]) check_vec(vecs[i], 1'b0);

    // Start pulse mid-blit must not disturb the running command.
    check_vec(vecs[0], 1'b1);

    // Clear: check the leading writes, then abort with reset.
    @(negedge clk);
    bif.start = 1'b1; bif.clear = 1'b1; bif.fill_color = 5'h04;
    @(posedge clk);
    #1;
    bif.start = 1'b0; bif.fill_color = 5'h09;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      chk("clr_we", int'(bif.fb_we), 1);
      chk("clr_addr", int'(bif.fb_addr), c - 1);
      chk("clr_data", int'(bif.fb_data), 4);
      chk("clr_busy", int'(bif.busy), 1);
      chk("clr_done", int'(bif.done), 0);
    end
    rst = 1'b1;
    #1;
    chk("clr_rst_we", int'(bif.fb_we), 0);
    chk("clr_rst_busy", int'(bif.busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in cycle 3 of a 4x4 blit, while a write is in flight.
    @(negedge clk);
    bif.start = 1'b1; bif.clear = 1'b0;
    bif.spr_x = 11'd20; bif.spr_y = 11'd20;
    bif.spr_w = 7'd4; bif.spr_h = 7'd4;
    bif.rom_base = 12'd500;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_we", int'(bif.fb_we), 1);
    chk("pre_rst_addr", int'(bif.fb_addr), 20 * 640 + 21);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", int'(bif.fb_we), 0);
    chk("mid_rst_busy", int'(bif.busy), 0);
    chk("mid_rst_rom", int'(bif.rom_addr), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(bif.busy), 0);
    chk("post_rst_done", int'(bif.done), 0);
    check_vec(vecs[0], 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_blit($urandom_range(0, 780) - 80,
               $urandom_range(0, 600) - 80,
               $urandom_range(0, 64),
               $urandom_range(0, 64),
               $urandom_range(0, 4095), 1'b0,
               nwr, dc, fa, fc);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
Writer-side engine for the double-buffered 5-bit frame buffer. It copies a rectangular sprite from a synchronous sprite ROM into the back buffer, one pixel per clock. Pixels outside the screen are clipped, and pixels equal to the transparent code are skipped. It also provides a full-screen clear command that fills every address with a given colour code. It sits between game/sprite control logic and the frame buffer write port.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
FB_AW, 19, frame buffer address width
ROM_AW, 12, sprite ROM address width
TRANSPARENT, 5'h15, colour code never written

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
clear  in  1  command select at start: 1 = clear screen, 0 = blit
spr_x  in  11  signed sprite left edge
spr_y  in  11  signed sprite top edge
spr_w  in  7  sprite width, 0..64
spr_h  in  7  sprite height, 0..64
rom_base  in  ROM_AW  ROM address of sprite pixel (0,0)
fill_color  in  5  colour code used by clear
rom_addr  out  ROM_AW  sprite ROM read address
rom_data  in  5  ROM data; valid one cycle after rom_addr
fb_we  out  1  frame buffer write enable
fb_addr  out  FB_AW  frame buffer write address
fb_data  out  5  frame buffer write data
busy  out  1  command in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous) forces state IDLE and drives all outputs and internal counters to 0. Asserting it mid-operation drops fb_we in the same cycle and abandons the command.
- States: IDLE, CLEAR, BLIT, DRAIN, DONE.
- busy = 1 in CLEAR, BLIT and DRAIN. done = 1 only in DONE.
- DONE always returns to IDLE on the next clock. A start seen in any state other than IDLE is ignored.
- Command acceptance: on the clock edge in IDLE with start = 1, all operand inputs are latched; later input changes have no effect on the running command.
  - clear = 1 goes to CLEAR.
  - clear = 0 with spr_w = 0 or spr_h = 0 goes directly to DONE, with no writes.
  - Otherwise go to BLIT.
- CLEAR:
  - A counter runs 0..SCREEN_W*SCREEN_H-1.
  - Each cycle: fb_we = 1, fb_addr = counter, fb_data = latched fill_color.
  - After address 307199, go to DONE.
- BLIT, stage 1:
  - Row-major scan: row 0..h-1 (outer), col 0..w-1 (inner), one pixel per cycle.
  - rom_addr = rom_base + row*w + col, truncated to ROM_AW (wraps modulo 2^ROM_AW).
  - Screen coordinates: sx = spr_x + col, sy = spr_y + row, as 12-bit signed.
  - The in-range flag is set when 0 <= sx < SCREEN_W and 0 <= sy < SCREEN_H.
- BLIT, stage 2 (one cycle later, aligned with rom_data):
  - fb_we = in_range AND (rom_data != TRANSPARENT).
  - fb_addr = sy*SCREEN_W + sx, computed in FB_AW bits.
  - fb_data = rom_data.
- After the last pixel is issued, go to DRAIN (one cycle carrying the final stage-2 write), then DONE.
- Whenever fb_we = 0, fb_addr and fb_data are driven to 0.
- Latency, with start sampled at edge 0:
  - Blit of N = w*h pixels: rom_addr for pixel k in cycle k+1; its write in cycle k+2; done in cycle N+2.
  - Clear: writes in cycles 1..307200; done in cycle 307201.
  - Zero-size blit: done in cycle 1.
- Fully off-screen sprite: takes the full w*h+2 cycles with no writes.

Decomposition:
- blitter_pkg holds:
  - state enum type
  - SCREEN_W, SCREEN_H, FB_DEPTH (307200)
  - TRANSPARENT_CODE
  - coordinate typedef (12-bit signed)
- Sub-module blit_addr_gen: the row/col counters, ROM address adder, signed sx/sy computation and in-range flag. Outputs: rom_addr, sx, sy, in_range, last.

Test Plan:
1. Reset held, then released -> fb_we, busy, done, rom_addr, fb_addr, fb_data all 0; state IDLE.
2. Blit spr_x=10, spr_y=5, w=2, h=2, rom_base=100, ROM[100..103] = {3, 15h, 7, 9}:
   - rom_addr 100..103 in cycles 1..4.
   - Writes: addr 3210 data 3 in cycle 2; no write in cycle 3; 3850 data 7 in cycle 4; 3851 data 9 in cycle 5.
   - done = 1 in cycle 6 only.
3. Clip: spr_x=-1, spr_y=479, w=2, h=2, all ROM data 1 -> exactly one write, addr 306560 data 1; done in cycle 6.
4. Clear, fill_color=5'h04 -> 307200 consecutive writes, addr 0..307199, data 4; busy high throughout; done in cycle 307201.
5. Blit with w=0 -> done in cycle 1, no fb_we. A start pulse during a running blit -> ignored; write sequence unchanged.
6. Reset asserted in cycle 3 of a 4x4 blit -> fb_we low in the same cycle; after release, IDLE, and a new start is accepted normally.
